// File: rtl/rs_decode_stream_ctrl_if.sv
// Frame-side and core-side signal bundle for the RS decode stream controller.
// slave is the controller's view; master is the view of whatever drives it.
interface rs_decode_stream_ctrl_if #(
    parameter int unsigned SYM_W = 8,
    parameter int unsigned N_MAX = 200,
    parameter int unsigned CNT_W = $clog2(N_MAX + 1)
);
    logic                   start;
    logic [CNT_W-1:0]       k_len;
    logic                   correct_en;
    logic [N_MAX*SYM_W-1:0] frame_in;
    logic                   ready;
    logic                   busy;
    logic                   done;
    logic                   result_valid;
    logic [N_MAX*SYM_W-1:0] frame_out;
    logic [N_MAX*SYM_W-1:0] err_mask;
    logic [CNT_W-1:0]       err_count;
    logic                   with_error;
    logic                   timeout;
    logic                   cfg_err;
    logic [SYM_W-1:0]       core_x;
    logic                   core_enable;
    logic [7:0]             core_k;
    logic                   core_clrn;
    logic [SYM_W-1:0]       core_error;
    logic                   core_valid;
    logic                   core_with_error;

    modport slave (
        input  start, k_len, correct_en, frame_in, core_error, core_valid, core_with_error,
        output ready, busy, done, result_valid, frame_out, err_mask, err_count, with_error,
               timeout, cfg_err, core_x, core_enable, core_k, core_clrn
    );

    modport master (
        output start, k_len, correct_en, frame_in, core_error, core_valid, core_with_error,
        input  ready, busy, done, result_valid, frame_out, err_mask, err_count, with_error,
               timeout, cfg_err, core_x, core_enable, core_k, core_clrn
    );
endinterface

// File: rtl/rs_decode_stream_ctrl.sv
// Frame controller for the rsdec core: feeds k_len symbols, collects the error pattern,
// and presents a corrected (or raw) frame with error statistics and a watchdog.
module rs_decode_stream_ctrl #(
    parameter int unsigned SYM_W   = 8,
    parameter int unsigned N_MAX   = 200,
    parameter int unsigned CNT_W   = $clog2(N_MAX + 1),
    parameter int unsigned TIMEOUT = 1024
) (
    input logic                  clk,
    input logic                  rst_n,
    input logic                  clrn,
    rs_decode_stream_ctrl_if.slave bus
);
    localparam int unsigned FW   = N_MAX * SYM_W;
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {StIdle, StFeed, StWait, StCollect, StDone} state_e;

    typedef struct packed {
        state_e           state;
        logic             ready;
        logic             busy;
        logic             done;
        logic             rv;
        logic             timeout;
        logic             cfg_err;
        logic             ce;
        logic             we;
        logic             core_en;
        logic [SYM_W-1:0] core_x;
        logic [CNT_W-1:0] k;
        logic [CNT_W-1:0] idx;
        logic [CNT_W-1:0] j;
        logic [CNT_W-1:0] cnt;
        logic [WD_W-1:0]  wd;
        logic [FW-1:0]    data;
        logic [FW-1:0]    mask;
    } ctl_t;

    function automatic ctl_t ctl_rst();
        ctl_t c;
        c       = '0;
        c.ready = 1'b1;
        return c;
    endfunction

    ctl_t r_ctl;
    logic w_k_ok;

    assign w_k_ok = (bus.k_len != '0) && (bus.k_len <= CNT_W'(N_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl <= ctl_rst();
        end else if (!clrn) begin
            r_ctl <= ctl_rst();
        end else begin
            r_ctl.done    <= 1'b0;
            r_ctl.cfg_err <= 1'b0;
            unique case (r_ctl.state)
                StIdle: begin
                    if (bus.start && w_k_ok) begin
                        r_ctl.data    <= bus.frame_in;
                        r_ctl.k       <= bus.k_len;
                        r_ctl.ce      <= bus.correct_en;
                        r_ctl.rv      <= 1'b0;
                        r_ctl.timeout <= 1'b0;
                        r_ctl.we      <= 1'b0;
                        r_ctl.cnt     <= '0;
                        r_ctl.mask    <= '0;
                        r_ctl.wd      <= '0;
                        r_ctl.j       <= '0;
                        r_ctl.ready   <= 1'b0;
                        r_ctl.busy    <= 1'b1;
                        // Symbol 0 goes out on the accept edge, straight from the input bus.
                        r_ctl.core_en <= 1'b1;
                        r_ctl.core_x  <= bus.frame_in[SYM_W-1:0];
                        r_ctl.idx     <= CNT_W'(1);
                        r_ctl.state   <= StFeed;
                    end else if (bus.start) begin
                        r_ctl.cfg_err <= 1'b1;
                    end
                end
                StFeed: begin
                    r_ctl.we <= r_ctl.we | bus.core_with_error;
                    if (r_ctl.idx == r_ctl.k) begin
                        r_ctl.core_en <= 1'b0;
                        r_ctl.core_x  <= '0;
                        r_ctl.state   <= StWait;
                    end else begin
                        r_ctl.core_x <= r_ctl.data[int'(r_ctl.idx) * SYM_W +: SYM_W];
                        r_ctl.idx    <= r_ctl.idx + CNT_W'(1);
                    end
                end
                StWait, StCollect: begin
                    r_ctl.we <= r_ctl.we | bus.core_with_error;
                    if (bus.core_valid) begin
                        r_ctl.wd <= '0;
                        r_ctl.mask[int'(r_ctl.j) * SYM_W +: SYM_W] <= bus.core_error;
                        if (bus.core_error != '0) begin
                            r_ctl.cnt <= r_ctl.cnt + CNT_W'(1);
                        end
                        r_ctl.j <= r_ctl.j + CNT_W'(1);
                        if (r_ctl.j == r_ctl.k - CNT_W'(1)) begin
                            r_ctl.done  <= 1'b1;
                            r_ctl.rv    <= 1'b1;
                            r_ctl.busy  <= 1'b0;
                            r_ctl.state <= StDone;
                        end else begin
                            r_ctl.state <= StCollect;
                        end
                    end else if (r_ctl.wd == WD_W'(TIMEOUT - 1)) begin
                        r_ctl.timeout <= 1'b1;
                        r_ctl.done    <= 1'b1;
                        r_ctl.rv      <= 1'b1;
                        r_ctl.busy    <= 1'b0;
                        r_ctl.state   <= StDone;
                    end else begin
                        r_ctl.wd <= r_ctl.wd + WD_W'(1);
                    end
                end
                StDone: begin
                    r_ctl.ready <= 1'b1;
                    r_ctl.state <= StIdle;
                end
                default: r_ctl.state <= StIdle;
            endcase
        end
    end

    // Mask symbols at or beyond k_len are never written, so the XOR passes them through.
    assign bus.frame_out    = r_ctl.rv ? (r_ctl.data ^ (r_ctl.ce ? r_ctl.mask : '0)) : '0;
    assign bus.err_mask     = r_ctl.rv ? r_ctl.mask : '0;
    assign bus.err_count    = r_ctl.rv ? r_ctl.cnt : '0;
    assign bus.with_error   = r_ctl.rv & (r_ctl.we | (r_ctl.cnt != '0));
    assign bus.ready        = r_ctl.ready;
    assign bus.busy         = r_ctl.busy;
    assign bus.done         = r_ctl.done;
    assign bus.result_valid = r_ctl.rv;
    assign bus.timeout      = r_ctl.timeout;
    assign bus.cfg_err      = r_ctl.cfg_err;
    assign bus.core_x       = r_ctl.core_x;
    assign bus.core_enable  = r_ctl.core_en;
    assign bus.core_k       = 8'(r_ctl.k);
    assign bus.core_clrn    = rst_n & clrn;
endmodule

// File: tb/tb_rs_decode_stream_ctrl.sv
// Randomised scoreboard bench for rs_decode_stream_ctrl with a behavioural rsdec core model.
module tb_rs_decode_stream_ctrl;
    localparam int SYM_W   = 8;
    localparam int N_MAX   = 200;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 1024;
    localparam int FW      = N_MAX * SYM_W;

    typedef struct {
        logic [FW-1:0] out;
        logic [FW-1:0] mask;
        int            cnt;
        bit            we;
        bit            to;
        longint        done_cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic clrn;

    rs_decode_stream_ctrl_if bus ();

    rs_decode_stream_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clrn  (clrn),
        .bus   (bus)
    );

    int     n_checks = 0;
    int     n_fail   = 0;
    longint cyc      = 0;
    exp_t   exp_q[$];

    // Core model configuration, written by the stimulus before each accept.
    logic [SYM_W-1:0] core_plan[N_MAX];
    logic [FW-1:0]    core_data;
    int               core_k     = 0;
    int               core_gap   = 0;
    bit               core_cwe   = 1'b0;
    bit               core_armed = 1'b0;

    logic [FW-1:0] cur_frame;
    longint        done_seen_cyc = -10;
    int            last_cnt      = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #3000000;
        $display("FAIL global_time_limit: simulation still running at %0t, required finished", $time);
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_bus(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 0; i < N_MAX; i++) begin
                if (act[i*SYM_W +: SYM_W] !== exp[i*SYM_W +: SYM_W]) begin
                    $display("FAIL %s: symbol %0d got %0h expected %0h", name, i,
                             act[i*SYM_W +: SYM_W], exp[i*SYM_W +: SYM_W]);
                    break;
                end
            end
        end
    endtask

    // Core model: checks fed symbols, then answers with the planned error pattern.
    initial begin
        int en_cnt = 0;
        bit prev_en = 1'b0;
        bus.core_valid      = 1'b0;
        bus.core_error      = '0;
        bus.core_with_error = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.core_enable) begin
                if (en_cnt < N_MAX) chk("core_x", 64'(bus.core_x), 64'(core_data[en_cnt*SYM_W +: SYM_W]));
                en_cnt++;
            end else if (prev_en) begin
                if (core_armed) begin
                    chk("feed_len", 64'(en_cnt), 64'(core_k));
                    if (core_gap != 2) begin
                        for (int j = 0; j < core_k; j++) begin
                            while (core_gap == 1 && $urandom_range(1, 0) == 1) begin
                                bus.core_valid = 1'b0;
                                @(posedge clk);
                                #1;
                            end
                            bus.core_valid      = 1'b1;
                            bus.core_error      = core_plan[j];
                            bus.core_with_error = core_cwe;
                            @(posedge clk);
                            #1;
                        end
                        bus.core_valid      = 1'b0;
                        bus.core_error      = '0;
                        bus.core_with_error = 1'b0;
                    end
                end
                en_cnt = 0;
            end
            prev_en = bus.core_enable;
        end
    end

    // Monitor: pops one expected result per done pulse.
    initial forever begin
        @(posedge clk);
        #1;
        if (bus.done) begin
            done_seen_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk_bus("frame_out", bus.frame_out, e.out);
                chk_bus("err_mask", bus.err_mask, e.mask);
                chk("err_count", 64'(bus.err_count), 64'(e.cnt));
                chk("with_error", 64'(bus.with_error), 64'(e.we));
                chk("timeout", 64'(bus.timeout), 64'(e.to));
                chk("done_rv", 64'(bus.result_valid), 64'(1));
                chk("done_busy", 64'(bus.busy), 64'(0));
                if (e.done_cyc >= 0) chk("latency", 64'(cyc), 64'(e.done_cyc));
            end
        end
    end

    task automatic wait_ready();
        int w = 0;
        while (!bus.ready && w < 5000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!bus.ready) chk("ready_wait_bound", 64'(bus.ready), 64'(1));
    endtask

    // mode: 0 no errors, 1 0x5A at symbols 3 and 9, 2 random. gap: 0 none, 1 random, 2 never valid.
    task automatic send(input int k, input bit ce, input int mode, input int gap, input bit cwe,
                        input bit reuse, input bit b2b);
        exp_t e;
        int   w;
        wait_ready();
        if (!reuse) for (int i = 0; i < N_MAX; i++) cur_frame[i*SYM_W +: SYM_W] = SYM_W'($urandom);
        for (int i = 0; i < N_MAX; i++) begin
            core_plan[i] = '0;
            if (mode == 1 && (i == 3 || i == 9)) core_plan[i] = 8'h5A;
            if (mode == 2 && $urandom_range(3, 0) == 0) core_plan[i] = SYM_W'($urandom_range(255, 1));
        end
        core_k = k; core_gap = gap; core_cwe = cwe; core_armed = 1'b1; core_data = cur_frame;
        e.mask = '0;
        e.cnt  = 0;
        if (gap != 2) begin
            for (int i = 0; i < k; i++) begin
                e.mask[i*SYM_W +: SYM_W] = core_plan[i];
                if (core_plan[i] != 0) e.cnt++;
            end
        end
        e.out = ce ? (cur_frame ^ e.mask) : cur_frame;
        e.we  = cwe || (e.cnt != 0);
        e.to  = (gap == 2);
        if (gap == 0) e.done_cyc = cyc + 2 * k + 1;
        else if (gap == 2) e.done_cyc = cyc + 1 + k + TIMEOUT;
        else e.done_cyc = -1;
        if (b2b) chk("b2b_accept_cycle", 64'(cyc), 64'(done_seen_cyc + 1));
        last_cnt = e.cnt;
        exp_q.push_back(e);
        bus.start = 1'b1; bus.k_len = CNT_W'(k); bus.correct_en = ce; bus.frame_in = cur_frame;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("accept_busy", 64'(bus.busy), 64'(1));
        bus.k_len = CNT_W'($urandom_range(N_MAX, 1));
        bus.correct_en = ~ce;
        for (int i = 0; i < N_MAX; i++) bus.frame_in[i*SYM_W +: SYM_W] = SYM_W'($urandom);
        w = 0;
        while (!bus.done && w < 3000) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!bus.done) chk("done_wait_bound", 64'(bus.done), 64'(1));
    endtask

    task automatic start_aborted(input int k);
        wait_ready();
        core_armed = 1'b0;
        for (int i = 0; i < N_MAX; i++) cur_frame[i*SYM_W +: SYM_W] = SYM_W'($urandom);
        core_data = cur_frame;
        bus.start = 1'b1; bus.k_len = CNT_W'(k); bus.correct_en = 1'b1; bus.frame_in = cur_frame;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clrn = 1'b1;
        bus.start = 1'b0; bus.k_len = '0; bus.correct_en = 1'b0; bus.frame_in = '0;
        #22;
        chk("rst_core_clrn", 64'(bus.core_clrn), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.ready), 64'(1));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_rv", 64'(bus.result_valid), 64'(0));
        chk("rst_count", 64'(bus.err_count), 64'(0));
        chk("rst_core_en", 64'(bus.core_enable), 64'(0));
        chk("rst_core_k", 64'(bus.core_k), 64'(0));
        chk("rst_core_clrn_hi", 64'(bus.core_clrn), 64'(1));
        chk_bus("rst_frame_out", bus.frame_out, '0);

        send(200, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0);
        send(16, 1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
        send(16, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0);
        send(30, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0);
        send(10, 1'b1, 2, 0, 1'b0, 1'b0, 1'b1);
        send(12, 1'b1, 0, 0, 1'b1, 1'b0, 1'b0);
        send(5, 1'b1, 0, 2, 1'b0, 1'b0, 1'b0);
        send(7, 1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
        send(1, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0);

        // Illegal lengths: rejected, previous results kept.
        for (int t = 0; t < 2; t++) begin
            wait_ready();
            bus.start = 1'b1;
            bus.k_len = (t == 0) ? CNT_W'(0) : CNT_W'(201);
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            chk("cfg_err_pulse", 64'(bus.cfg_err), 64'(1));
            chk("cfg_ready", 64'(bus.ready), 64'(1));
            chk("cfg_core_en", 64'(bus.core_enable), 64'(0));
            chk("cfg_keep_rv", 64'(bus.result_valid), 64'(1));
            chk("cfg_keep_count", 64'(bus.err_count), 64'(last_cnt));
            @(posedge clk);
            #1;
            chk("cfg_err_clear", 64'(bus.cfg_err), 64'(0));
            chk("cfg_core_en2", 64'(bus.core_enable), 64'(0));
        end

        // Synchronous clear mid-frame.
        start_aborted(100);
        repeat (20) begin @(posedge clk); #1; end
        chk("pre_clrn_en", 64'(bus.core_enable), 64'(1));
        clrn = 1'b0;
        #1;
        chk("clrn_core_clrn", 64'(bus.core_clrn), 64'(0));
        @(posedge clk);
        #1;
        chk("clrn_ready", 64'(bus.ready), 64'(1));
        chk("clrn_busy", 64'(bus.busy), 64'(0));
        chk("clrn_core_en", 64'(bus.core_enable), 64'(0));
        clrn = 1'b1;

        send(20, 1'b1, 2, 1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset at FEED cycle 50.
        start_aborted(200);
        repeat (49) begin @(posedge clk); #1; end
        chk("pre_rst_en", 64'(bus.core_enable), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 64'(bus.ready), 64'(1));
        chk("arst_busy", 64'(bus.busy), 64'(0));
        chk("arst_core_en", 64'(bus.core_enable), 64'(0));
        chk("arst_core_clrn", 64'(bus.core_clrn), 64'(0));
        chk("arst_core_x", 64'(bus.core_x), 64'(0));
        chk_bus("arst_frame_out", bus.frame_out, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        for (int r = 0; r < 6; r++) begin
            send($urandom_range(40, 1), 1'($urandom_range(1, 0)), 2, $urandom_range(1, 0),
                 ($urandom_range(4, 0) == 0), 1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
